// File: rtl/imem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-ported memory with one
// outstanding transaction, data priority, bounded fetch starvation and fetch flush.
module imem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_if_req,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  input  logic                    i_if_flush,
  output logic                    o_if_gnt,
  output logic                    o_if_rvalid,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  input  logic                    i_d_req,
  input  logic                    i_d_we,
  input  logic [ADDR_WIDTH-1:0]   i_d_addr,
  input  logic [DATA_WIDTH-1:0]   i_d_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_d_be,
  output logic                    o_d_gnt,
  output logic                    o_d_rvalid,
  output logic [DATA_WIDTH-1:0]   o_d_rdata,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  input  logic                    i_mem_gnt,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_busy
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int SW   = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_DATA, OWN_FETCH} owner_t;

  state_t                state, state_nxt;
  owner_t                owner;
  logic [SW-1:0]         streak;
  logic                  drop;
  logic                  fetch_wins;
  logic                  if_gnt, d_gnt;
  logic                  resp;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_W-1:0]       mem_be;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    o_mem_req  = 1'b0;
    fetch_wins = i_if_req && (!i_d_req || (streak == SW'(MAX_DATA_STREAK)));
    case (state)
      IDLE: begin
        if (!i_reset) begin
          if_gnt = fetch_wins;
          d_gnt  = i_d_req && !fetch_wins;
        end
        if (if_gnt || d_gnt) state_nxt = ISSUE;
      end
      ISSUE: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (i_mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign resp = (state == WAIT) && i_mem_rvalid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      owner       <= OWN_DATA;
      streak      <= '0;
      drop        <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= '0;
      o_d_rvalid  <= 1'b0;
      o_d_rdata   <= '0;
    end else begin
      o_if_rvalid <= 1'b0;
      o_d_rvalid  <= 1'b0;
      if (if_gnt) begin
        owner     <= OWN_FETCH;
        mem_we    <= 1'b0;
        mem_addr  <= i_if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
        streak    <= '0;
      end else if (d_gnt) begin
        owner     <= OWN_DATA;
        mem_we    <= i_d_we;
        mem_addr  <= i_d_addr;
        mem_wdata <= i_d_wdata;
        mem_be    <= i_d_be;
        if (!i_if_req)                             streak <= '0;
        else if (streak != SW'(MAX_DATA_STREAK))   streak <= streak + SW'(1);
      end
      // A flush in the response cycle itself suppresses the pulse directly below.
      if (resp)
        drop <= 1'b0;
      else if (i_if_flush && (if_gnt || (state != IDLE && owner == OWN_FETCH)))
        drop <= 1'b1;
      if (resp) begin
        if (owner == OWN_DATA) begin
          o_d_rvalid <= 1'b1;
          o_d_rdata  <= mem_we ? '0 : i_mem_rdata;
        end else if (!drop && !i_if_flush) begin
          o_if_rvalid <= 1'b1;
          o_if_rdata  <= i_mem_rdata;
        end
      end
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_d_gnt     = d_gnt;
  assign o_mem_we    = mem_we;
  assign o_mem_addr  = mem_addr;
  assign o_mem_wdata = mem_wdata;
  assign o_mem_be    = mem_be;
  assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: reset, load latency, arbitration fairness,
// memory backpressure, fetch flush and mid-transaction reset.
module tb_imem_port_arbiter;

  logic        i_clk, i_reset;
  logic        i_if_req, i_if_flush;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_d_req, i_d_we;
  logic [31:0] i_d_addr, i_d_wdata;
  logic [3:0]  i_d_be;
  logic        o_d_gnt, o_d_rvalid;
  logic [31:0] o_d_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_gnt, i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_busy;
  logic [138:0] all_outs;

  int checks = 0;
  int failures = 0;

  imem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_DATA_STREAK(4)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .i_d_be(i_d_be), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  assign all_outs = {o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
                     o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_busy};

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_if_req = 0; i_if_addr = '0; i_if_flush = 0;
    i_d_req = 0; i_d_we = 0; i_d_addr = '0; i_d_wdata = '0; i_d_be = '0;
    i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    tick; tick;
    #1;
    checks++;
    if (all_outs !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs);
    end
    i_reset = 1'b0;
    tick;
  endtask

  task automatic test_single_load;
    i_d_req = 1; i_d_we = 0; i_d_addr = 32'h40; i_d_be = 4'hF; #1;
    checks++;
    if ({o_d_gnt, o_if_gnt, o_mem_req} !== 3'b100) begin
      failures++; $display("FAIL load_grant got=%b exp=100", {o_d_gnt, o_if_gnt, o_mem_req});
    end
    tick;
    i_d_req = 0; i_d_addr = 32'hFFFF_FFF0; i_mem_gnt = 1; #1;
    checks++;
    if ({o_mem_req, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
      failures++; $display("FAIL load_issue got=%b/%b/%h exp=1/0/40", o_mem_req, o_mem_we, o_mem_addr);
    end
    tick;
    i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hDEAD_BEEF; #1;
    checks++;
    if ({o_mem_req, o_d_rvalid, o_busy} !== 3'b001) begin
      failures++; $display("FAIL load_wait got=%b exp=001", {o_mem_req, o_d_rvalid, o_busy});
    end
    tick;
    i_mem_rvalid = 0; i_mem_rdata = '0; #1;
    checks++;
    if ({o_d_rvalid, o_if_rvalid, o_busy, o_d_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL load_resp got=%b/%h exp=100/deadbeef", {o_d_rvalid, o_if_rvalid, o_busy}, o_d_rdata);
    end
    tick;
    checks++;
    if (o_d_rvalid !== 1'b0) begin
      failures++; $display("FAIL load_pulse got=%b exp=0", o_d_rvalid);
    end
  endtask

  task automatic test_contention;
    logic [18:0] exp_f;
    logic [18:0] if_pat;
    logic        prev_f;
    logic [31:0] prev_d;
    exp_f = '0; exp_f[4] = 1; exp_f[9] = 1; exp_f[18] = 1;
    if_pat = '1; if_pat[13] = 0;
    prev_f = 0; prev_d = '0;
    i_d_we = 0; i_if_addr = 32'h100; i_d_addr = 32'h200; i_d_be = 4'hF; i_d_req = 1;
    for (int k = 0; k < 19; k++) begin
      i_if_req = if_pat[k]; #1;
      checks++;
      if ({o_if_gnt, o_d_gnt} !== (exp_f[k] ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL arb_order k=%0d got=%b exp=%b", k, {o_if_gnt, o_d_gnt}, exp_f[k] ? 2'b10 : 2'b01);
      end
      if (k > 0) begin
        checks++;
        if ({o_if_rvalid, o_d_rvalid, (prev_f ? o_if_rdata : o_d_rdata)} !== {prev_f, !prev_f, prev_d}) begin
          failures++; $display("FAIL arb_resp k=%0d got=%b%b/%h exp=%b%b/%h", k, o_if_rvalid, o_d_rvalid,
                               prev_f ? o_if_rdata : o_d_rdata, prev_f, !prev_f, prev_d);
        end
      end
      tick;
      i_mem_gnt = 1; #1;
      checks++;
      if (o_mem_addr !== (exp_f[k] ? 32'h100 : 32'h200)) begin
        failures++; $display("FAIL arb_addr k=%0d got=%h exp=%h", k, o_mem_addr, exp_f[k] ? 32'h100 : 32'h200);
      end
      tick;
      i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h1000 + k;
      tick;
      i_mem_rvalid = 0;
      prev_f = exp_f[k]; prev_d = 32'h1000 + k;
    end
    i_if_req = 0; i_d_req = 0; #1;
    checks++;
    if ({o_if_rvalid, o_if_rdata} !== {1'b1, prev_d}) begin
      failures++; $display("FAIL arb_last got=%b/%h exp=1/%h", o_if_rvalid, o_if_rdata, prev_d);
    end
    tick;
  endtask

  task automatic test_backpressure;
    i_d_req = 1; i_d_we = 1; i_d_addr = 32'h10; i_d_wdata = 32'hA5A5_1234; i_d_be = 4'b0011; #1;
    checks++;
    if (o_d_gnt !== 1'b1) begin
      failures++; $display("FAIL bp_grant got=%b exp=1", o_d_gnt);
    end
    tick;
    i_d_req = 0; i_d_we = 0; i_d_addr = 32'hDEAD_0000; i_d_wdata = '0; i_d_be = 4'hF;
    for (int c = 0; c < 6; c++) begin
      i_mem_gnt = (c == 5); #1;
      checks++;
      if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be} !==
          {1'b1, 1'b1, 32'h10, 32'hA5A5_1234, 4'b0011}) begin
        failures++; $display("FAIL bp_hold c=%0d got=%b/%b/%h/%h/%b exp=1/1/10/a5a51234/0011",
                             c, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be);
      end
      tick;
    end
    i_mem_gnt = 0; i_mem_rvalid = 0; #1;
    checks++;
    if ({o_mem_req, o_busy} !== 2'b01) begin
      failures++; $display("FAIL bp_wait got=%b exp=01", {o_mem_req, o_busy});
    end
    tick;
    i_mem_rvalid = 1; i_mem_rdata = 32'hFFFF_FFFF;
    tick;
    i_mem_rvalid = 0; #1;
    checks++;
    if ({o_d_rvalid, o_d_rdata} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL bp_store_ack got=%b/%h exp=1/0", o_d_rvalid, o_d_rdata);
    end
    tick;
  endtask

  task automatic test_flush;
    // flush position: 0 none, 1 grant cycle, 2 ISSUE, 3 WAIT (no rvalid), 4 response cycle
    logic [31:0] addrs [5];
    logic [31:0] rds   [5];
    int          pos   [5];
    addrs = '{32'h8, 32'h20, 32'h30, 32'h34, 32'h38};
    rds   = '{32'h13, 32'h1234_5678, 32'h0BAD_C0DE, 32'h5555_AAAA, 32'h7777_0001};
    pos   = '{3, 0, 4, 1, 2};
    for (int t = 0; t < 5; t++) begin
      i_if_req = 1; i_if_addr = addrs[t]; i_if_flush = (pos[t] == 1); #1;
      checks++;
      if (o_if_gnt !== 1'b1) begin
        failures++; $display("FAIL flush_grant t=%0d got=%b exp=1", t, o_if_gnt);
      end
      tick;
      i_if_req = 0; i_if_flush = (pos[t] == 2); i_mem_gnt = 1; #1;
      checks++;
      if ({o_mem_we, o_mem_be, o_mem_addr} !== {1'b0, 4'hF, addrs[t]}) begin
        failures++; $display("FAIL fetch_fields t=%0d got=%b/%b/%h exp=0/1111/%h", t, o_mem_we, o_mem_be, o_mem_addr, addrs[t]);
      end
      tick;
      i_mem_gnt = 0; i_if_flush = (pos[t] == 3);
      tick;
      i_if_flush = (pos[t] == 4); i_mem_rvalid = 1; i_mem_rdata = rds[t];
      tick;
      i_mem_rvalid = 0; i_if_flush = 0; #1;
      checks++;
      if (o_if_rvalid !== (pos[t] == 0)) begin
        failures++; $display("FAIL flush_rvalid t=%0d got=%b exp=%b", t, o_if_rvalid, pos[t] == 0);
      end
      if (pos[t] == 0) begin
        checks++;
        if (o_if_rdata !== rds[t]) begin
          failures++; $display("FAIL flush_rdata t=%0d got=%h exp=%h", t, o_if_rdata, rds[t]);
        end
      end
      tick;
    end
    i_d_req = 1; i_d_we = 0; i_d_addr = 32'h44; i_d_be = 4'hF; i_if_flush = 1; #1;
    checks++;
    if (o_d_gnt !== 1'b1) begin
      failures++; $display("FAIL flush_data_grant got=%b exp=1", o_d_gnt);
    end
    tick;
    i_d_req = 0; i_mem_gnt = 1;
    tick;
    i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFE_F00D;
    tick;
    i_mem_rvalid = 0; i_if_flush = 0; #1;
    checks++;
    if ({o_d_rvalid, o_if_rvalid, o_d_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL flush_data_resp got=%b/%h exp=10/cafef00d", {o_d_rvalid, o_if_rvalid}, o_d_rdata);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    i_if_req = 1; i_if_addr = 32'h50; #1;
    tick;
    i_if_req = 0; i_mem_gnt = 1;
    tick;
    i_mem_gnt = 0; #1;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++; $display("FAIL rst_mid_wait got=%b exp=1", o_busy);
    end
    i_reset = 1;
    tick;
    i_reset = 0; i_if_req = 1; i_if_addr = 32'h60; #1;
    checks++;
    if (all_outs !== {1'b1, 138'b0}) begin
      failures++; $display("FAIL rst_mid_outputs got=%h exp=%h", all_outs, {1'b1, 138'b0});
    end
    tick;
    i_if_req = 0; i_mem_gnt = 1; #1;
    checks++;
    if ({o_mem_req, o_mem_addr} !== {1'b1, 32'h60}) begin
      failures++; $display("FAIL rst_refetch_issue got=%b/%h exp=1/60", o_mem_req, o_mem_addr);
    end
    tick;
    i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h0000_600D;
    tick;
    i_mem_rvalid = 0; #1;
    checks++;
    if ({o_if_rvalid, o_if_rdata} !== {1'b1, 32'h0000_600D}) begin
      failures++; $display("FAIL rst_refetch_resp got=%b/%h exp=1/600d", o_if_rvalid, o_if_rdata);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_single_load;
    test_contention;
    test_backpressure;
    test_flush;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-ported backing memory between the instruction-fetch requester and the data (load/store) requester.
- This is the path for replacing the fetch stage's private instruction array with a unified memory.
- Serialises accesses with one outstanding transaction, data-priority arbitration and a bounded-starvation guarantee for fetch.
- Provides a fetch flush that discards the in-flight fetch response after a taken branch.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
DATA_WIDTH, 32, data word width; must be a multiple of 8
MAX_DATA_STREAK, 4, consecutive contested data grants allowed before fetch is forced; must be ≥ 1

Ports:
i_clk  in  1  clock; one clock domain
i_reset  in  1  reset, synchronous, active-high
i_if_req  in  1  fetch request; held with i_if_addr stable until o_if_gnt
i_if_addr  in  ADDR_WIDTH  fetch address
i_if_flush  in  1  discard any granted, not-yet-returned fetch
o_if_gnt  out  1  fetch request accepted this cycle
o_if_rvalid  out  1  fetch data valid, one-cycle pulse
o_if_rdata  out  DATA_WIDTH  fetched instruction word
i_d_req  in  1  data request; held with fields stable until o_d_gnt
i_d_we  in  1  1 = store, 0 = load
i_d_addr  in  ADDR_WIDTH  data address
i_d_wdata  in  DATA_WIDTH  store data
i_d_be  in  DATA_WIDTH/8  store byte enables
o_d_gnt  out  1  data request accepted this cycle
o_d_rvalid  out  1  load data or store ack, one-cycle pulse
o_d_rdata  out  DATA_WIDTH  load data; 0 for store acks
o_mem_req  out  1  memory request, held until i_mem_gnt
o_mem_we  out  1  memory write enable
o_mem_addr  out  ADDR_WIDTH  memory address
o_mem_wdata  out  DATA_WIDTH  memory write data
o_mem_be  out  DATA_WIDTH/8  memory byte enables; all-ones for fetches
i_mem_gnt  in  1  memory accepted request
i_mem_rvalid  in  1  memory response, one cycle per request; also acks writes
i_mem_rdata  in  DATA_WIDTH  memory read data
o_busy  out  1  state != IDLE

Behaviour:
- Reset:
  - state = IDLE; all outputs 0; streak counter = 0; owner = DATA; drop flag = 0.
  - Reset mid-transaction abandons it; the memory is reset alongside.
- FSM IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - o_X_gnt is combinational: asserted only in IDLE when the winner's req is high.
  - On grant, latch owner, addr, we, wdata and be; for fetch, we = 0 and be = all-ones. Next state is ISSUE.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
- Streak counter:
  - Increments on a data grant while i_if_req is also high.
  - Clears on any fetch grant, or on a data grant with i_if_req low.
  - Saturates at MAX_DATA_STREAK.
- ISSUE:
  - o_mem_req = 1 with latched fields.
  - On i_mem_gnt, go to WAIT; otherwise hold and keep fields stable.
  - i_mem_rvalid is ignored in ISSUE; memory never responds in its grant cycle.
- WAIT:
  - On i_mem_rvalid, go to IDLE and register the response for one cycle.
  - Owner DATA: o_d_rvalid = 1; o_d_rdata = i_mem_rdata for loads, 0 for stores.
  - Owner FETCH with drop flag clear: o_if_rvalid = 1; o_if_rdata = i_mem_rdata.
  - The next grant may occur in the same cycle as the rvalid pulse.
- Latency: grant at cycle N → o_mem_req at N+1 → earliest o_X_rvalid at N+3, assuming i_mem_gnt at N+1 and i_mem_rvalid at N+2.
- Flush:
  - i_if_flush high while owner = FETCH in ISSUE/WAIT, on the fetch-grant cycle, or on the i_mem_rvalid cycle sets the drop flag.
  - The memory transaction still completes; its o_if_rvalid is suppressed.
  - The drop flag clears on return to IDLE.
  - Flush has no effect on a data transaction.
  - Flush does not block a new fetch grant in a later IDLE cycle.
- Unused rdata outputs hold their last value; consumers qualify them with rvalid.

Test Plan:
- Single load: i_d_req, addr 0x40, memory returns 0xDEADBEEF after gnt at first ISSUE cycle → o_d_gnt at cycle 0, o_mem_req cycle 1, o_d_rvalid with 0xDEADBEEF at cycle 3, o_if_rvalid never set.
- Contention and fairness: both req held continuously, MAX_DATA_STREAK = 4 → grant order D,D,D,D,F,D,D,D,D,F; streak returns to 0 after each F.
- Memory backpressure: i_mem_gnt withheld 5 cycles on a store addr 0x10, be 4'b0011 → o_mem_req and fields stable for all 6 ISSUE cycles; o_d_rvalid with rdata 0 after the response.
- Flush: fetch addr 0x8 granted; i_if_flush pulsed in WAIT; memory returns 0x00000013 → no o_if_rvalid. A following fetch to 0x20 returns its data normally.
- Flush on the response cycle, and flush during a data transaction → fetch response dropped; data response delivered unchanged.
- Reset asserted in WAIT → next cycle all outputs 0 and o_busy = 0; a new fetch request after reset is granted in its first IDLE cycle.
